// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
module dmem_responder #(
   parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
   parameter int unsigned DMEM_SIZE = 32768,
   parameter string       INIT_FILE = "target/data.mif",
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_read_status,
   input  logic [1:0]  req_write_status,
   input  logic        req_load_signed,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        busy
);
   localparam int unsigned AW        = (DMEM_SIZE > 1) ? $clog2(DMEM_SIZE) : 1;
   localparam logic [31:0] WIN_BYTES = 32'(DMEM_SIZE * 4);
   localparam logic [3:0]  LAT       = 4'(LATENCY);
   localparam bit          HAS_IMAGE = (INIT_FILE != "");

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   localparam logic [1:0] SZ_WORD = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  rd_q, rd_d;
   logic [1:0]  wr_q, wr_d;
   logic        sgn_q, sgn_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] mem_array [DMEM_SIZE];

   logic [31:0] off;
   logic [AW-1:0] idx;
   logic [1:0]  lane;
   logic        req_err;
   logic [31:0] mem_word, shifted, load_val, wr_word;
   logic [3:0]  wr_be;
   logic        commit, store_en;
   logic        unused_bits;

   // Decode the latched request: range, alignment, load extension and store lanes
   always_comb begin
      off      = addr_q - DMEM_BASE;
      idx      = off[AW+1:2];
      lane     = addr_q[1:0];
      req_err  = (off >= WIN_BYTES)
               || (((rd_q == SZ_HALF) || (wr_q == SZ_HALF)) && addr_q[0])
               || (((rd_q == SZ_WORD) || (wr_q == SZ_WORD)) && (addr_q[1:0] != 2'b00))
               || ((rd_q != 2'b00) && (wr_q != 2'b00));
      mem_word = mem_array[idx];
      shifted  = mem_word >> {lane, 3'b000};
      load_val = '0;
      case (rd_q)
         SZ_BYTE: load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
         SZ_WORD: load_val = shifted;
         default: load_val = '0;
      endcase
      wr_be   = 4'b0000;
      wr_word = wdata_q;
      case (wr_q)
         SZ_BYTE: begin
            wr_be   = 4'b0001 << lane;
            wr_word = {4{wdata_q[7:0]}};
         end
         SZ_HALF: begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata_q[15:0]}};
         end
         SZ_WORD: wr_be = 4'b1111;
         default: wr_be = 4'b0000;
      endcase
   end

   // Handshake FSM: latch on accept, count wait states, commit once, hold until taken
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      addr_d       = addr_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      sgn_d        = sgn_q;
      wdata_d      = wdata_q;
      commit       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               rd_d    = req_read_status;
               wr_d    = req_write_status;
               sgn_d   = req_load_signed;
               wdata_d = req_wdata;
               cnt_d   = LAT;
               state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_RESP;
         end
         S_RESP: begin
            if (!resp_valid_q) begin
               // First RESP cycle is the commit edge; the response shows after it
               commit       = 1'b1;
               resp_valid_d = 1'b1;
               err_d        = req_err;
               rdata_d      = req_err ? 32'd0 : load_val;
            end else if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign store_en = commit && reset_n && !req_err && (wr_q != 2'b00);

   // State and response registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         resp_valid_q <= 1'b0;
         rdata_q      <= 32'd0;
         err_q        <= 1'b0;
         addr_q       <= 32'd0;
         rd_q         <= 2'b00;
         wr_q         <= 2'b00;
         sgn_q        <= 1'b0;
         wdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         sgn_q        <= sgn_d;
         wdata_q      <= wdata_d;
      end
   end

   // Byte-enabled store into the word array; contents survive reset
   always_ff @(posedge clk) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_array[idx][8*b +: 8] <= wr_word[8*b +: 8];
         end
      end
   end

   // INIT_FILE is consumed by the memory-image preload flow, not by this logic
   assign unused_bits = ^{off[31:AW+2], off[1:0], HAS_IMAGE};

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_error = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 2 and 0
module tb_dmem_responder;
   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam int unsigned SIZE = 32768;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr [2];
   logic [1:0]  req_rs [2];
   logic [1:0]  req_ws [2];
   logic        req_sgn [2];
   logic [31:0] req_wdata [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_error [2];
   logic        busy [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t exp_q [2][$];
   logic [31:0] model_mem [int unsigned];
   int acc_cyc [2];
   bit seen_valid [2];
   logic [31:0] hold_rdata [2];
   logic hold_err [2];

   dmem_responder #(.LATENCY(2)) u_lat2 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .req_read_status(req_rs[0]), .req_write_status(req_ws[0]),
      .req_load_signed(req_sgn[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .busy(busy[0])
   );

   dmem_responder #(.LATENCY(0)) u_lat0 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .req_read_status(req_rs[1]), .req_write_status(req_ws[1]),
      .req_load_signed(req_sgn[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .busy(busy[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: byte-addressed little-endian memory, sizes 1/2/4 bytes
   function automatic void model_apply(input int g, input logic [31:0] addr, input logic [1:0] rd,
                                       input logic [1:0] wr, input logic sgn, input logic [31:0] wdata,
                                       output logic [31:0] er, output logic ee);
      logic [31:0] off, w, mask;
      int nb, lane;
      int unsigned key;
      off = addr - BASE;
      er  = '0;
      ee  = 1'b0;
      nb  = (rd != 0) ? (1 << (int'(rd) - 1)) : (wr != 0) ? (1 << (int'(wr) - 1)) : 0;
      if (off >= SIZE * 4 || (rd != 0 && wr != 0) || (nb != 0 && (addr % nb) != 0)) begin
         ee = 1'b1;
         return;
      end
      key  = int'(g) * 65536 + int'(off >> 2);
      lane = int'(off % 4);
      w    = model_mem.exists(key) ? model_mem[key] : '0;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (wr != 0) begin
         for (int b = 0; b < nb; b++) w[8*(lane+b) +: 8] = wdata[8*b +: 8];
         model_mem[key] = w;
      end else if (rd != 0) begin
         er = (w >> (8 * lane)) & mask;
         if (sgn && nb < 4 && er[8*nb-1]) er = er | ~mask;
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_mon
      always @(negedge clk) begin
         exp_t e;
         if (!reset_n) begin
            exp_q[g].delete();
            seen_valid[g] = 1'b0;
         end else begin
            if (req_valid[g] && req_ready[g]) acc_cyc[g] = cyc + 1;
            if (resp_valid[g]) begin
               if (!seen_valid[g]) begin
                  seen_valid[g] = 1'b1;
                  hold_rdata[g] = resp_rdata[g];
                  hold_err[g]   = resp_error[g];
                  check($sformatf("latency_inst%0d", g), cyc - acc_cyc[g], (g == 0 ? 2 : 0) + 1);
               end else begin
                  check($sformatf("rdata_stable_inst%0d", g), resp_rdata[g], hold_rdata[g]);
                  check($sformatf("err_stable_inst%0d", g), resp_error[g], hold_err[g]);
               end
               check($sformatf("req_ready_low_inst%0d", g), req_ready[g], 0);
               check($sformatf("busy_high_inst%0d", g), busy[g], 1);
               if (resp_ready[g]) begin
                  seen_valid[g] = 1'b0;
                  if (exp_q[g].size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_resp_inst%0d: got a response, expected none", g);
                  end else begin
                     e = exp_q[g].pop_front();
                     check($sformatf("rdata_inst%0d", g), resp_rdata[g], e.rdata);
                     check($sformatf("error_inst%0d", g), resp_error[g], e.err);
                  end
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input int g);
      check($sformatf("rst_req_ready_inst%0d", g), req_ready[g], 1);
      check($sformatf("rst_resp_valid_inst%0d", g), resp_valid[g], 0);
      check($sformatf("rst_rdata_inst%0d", g), resp_rdata[g], 0);
      check($sformatf("rst_error_inst%0d", g), resp_error[g], 0);
      check($sformatf("rst_busy_inst%0d", g), busy[g], 0);
   endtask

   task automatic do_req(input int g, input logic [31:0] addr, input logic [1:0] rd, input logic [1:0] wr,
                         input logic sgn, input logic [31:0] wdata, input int hold, input bit abort);
      exp_t e;
      int n;
      bit ok;
      @(posedge clk); #1;
      req_addr[g]  = addr;
      req_rs[g]    = rd;
      req_ws[g]    = wr;
      req_sgn[g]   = sgn;
      req_wdata[g] = wdata;
      req_valid[g] = 1'b1;
      ok = 1'b0;
      for (n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = req_ready[g];
      end
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      req_addr[g]  = $urandom;
      req_wdata[g] = $urandom;
      req_rs[g]    = 2'($urandom);
      req_ws[g]    = 2'($urandom);
      req_sgn[g]   = 1'($urandom);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout_inst%0d: req_ready got 0 expected 1", g);
         return;
      end
      if (abort) begin
         @(posedge clk); #1;
         check("busy_in_wait", busy[g], 1);
         reset_n = 1'b0;
         @(posedge clk); #1;
         check_reset_outputs(g);
         reset_n = 1'b1;
         return;
      end
      model_apply(g, addr, rd, wr, sgn, wdata, e.rdata, e.err);
      exp_q[g].push_back(e);
      n = 0;
      while (!resp_valid[g] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!resp_valid[g]) begin
         errors++;
         $display("FAIL resp_timeout_inst%0d: resp_valid got 0 expected 1", g);
         exp_q[g].delete();
         return;
      end
      repeat (hold) begin @(posedge clk); #1; end
      resp_ready[g] = 1'b1;
      @(posedge clk); #1;
      resp_ready[g] = 1'b0;
      check($sformatf("ready_after_hs_inst%0d", g), req_ready[g], 1);
      check($sformatf("valid_after_hs_inst%0d", g), resp_valid[g], 0);
   endtask

   task automatic rand_req(input int g);
      logic [31:0] addr;
      logic [1:0] rd, wr;
      int kind, sz;
      sz   = $urandom_range(1, 3);
      kind = $urandom_range(0, 19);
      addr = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rd = 2'b00;
      wr = 2'b00;
      if (kind < 8) rd = 2'(sz);
      else if (kind < 16) wr = 2'(sz);
      else if (kind == 16) begin
         rd = 2'(sz);
         wr = 2'($urandom_range(1, 3));
      end else if (kind == 17) begin
         rd = 2'(sz);
         addr = BASE - 4 * $urandom_range(1, 4);
      end else if (kind == 18) begin
         wr = 2'(sz);
         addr = BASE + SIZE * 4 + 4 * $urandom_range(0, 3);
      end else addr = BASE + 4 * $urandom_range(0, 7);
      do_req(g, addr, rd, wr, 1'($urandom), $urandom, $urandom_range(0, 3), 1'b0);
   endtask

   initial begin
      for (int g = 0; g < 2; g++) begin
         req_valid[g]  = 1'b0;
         req_addr[g]   = '0;
         req_rs[g]     = '0;
         req_ws[g]     = '0;
         req_sgn[g]    = 1'b0;
         req_wdata[g]  = '0;
         resp_ready[g] = 1'b0;
         acc_cyc[g]    = 0;
         seen_valid[g] = 1'b0;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) check_reset_outputs(g);
      reset_n = 1'b1;

      for (int g = 0; g < 2; g++)
         for (int w = 0; w < 8; w++) do_req(g, BASE + 4 * w, 2'b00, 2'b11, 1'b0, $urandom, 0, 1'b0);

      do_req(0, BASE + 4, 2'b00, 2'b11, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
      do_req(0, BASE + 4, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);
      do_req(0, BASE + 7, 2'b01, 2'b00, 1'b1, 32'h0, 0, 1'b0);
      do_req(0, BASE + 7, 2'b01, 2'b00, 1'b0, 32'h0, 0, 1'b0);
      do_req(0, BASE + 4, 2'b10, 2'b00, 1'b1, 32'h0, 0, 1'b0);
      do_req(0, BASE + 6, 2'b00, 2'b10, 1'b0, 32'h0000_1234, 0, 1'b0);
      do_req(0, BASE + 4, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);
      do_req(0, BASE + 5, 2'b00, 2'b01, 1'b0, 32'h0000_00AA, 0, 1'b0);
      do_req(0, BASE + 4, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);

      do_req(0, BASE + 2, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);
      do_req(0, 32'h000F_FFFC, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);
      do_req(0, BASE + SIZE * 4, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);
      do_req(0, BASE + 4, 2'b11, 2'b11, 1'b0, 32'h1111_2222, 0, 1'b0);
      do_req(0, BASE + 4, 2'b11, 2'b00, 1'b0, 32'h0, 5, 1'b0);

      do_req(0, BASE + 4, 2'b00, 2'b11, 1'b0, 32'h0000_0055, 0, 1'b1);
      do_req(0, BASE + 4, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);

      do_req(1, BASE + 8, 2'b00, 2'b11, 1'b0, 32'h8765_4321, 0, 1'b0);
      do_req(1, BASE + 10, 2'b10, 2'b00, 1'b1, 32'h0, 2, 1'b0);
      do_req(1, BASE + 3, 2'b11, 2'b00, 1'b0, 32'h0, 0, 1'b0);

      for (int i = 0; i < 120; i++) rand_req(i % 2);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
